// File: rtl/demux4_rr_sched_pkg.sv
// Shared constants for the 1-to-4 round-robin demux: channel indices and dispatch modes.
package demux4_rr_sched_pkg;

  typedef enum logic [1:0] {
    CH_A = 2'd0,
    CH_B = 2'd1,
    CH_C = 2'd2,
    CH_D = 2'd3
  } ch_e;

  typedef enum logic {
    MODE_RR     = 1'b0,
    MODE_DIRECT = 1'b1
  } mode_e;

  localparam int unsigned NUM_CH = 4;

endpackage

// File: rtl/demux4_rr_sched_if.sv
// Producer stream, four consumer channels and status for demux4_rr_sched.
interface demux4_rr_sched_if #(parameter int unsigned WIDTH = 4);

  logic             mode;
  logic [1:0]       sel;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;

  logic             a_valid, b_valid, c_valid, d_valid;
  logic [WIDTH-1:0] a_data, b_data, c_data, d_data;
  logic             a_ready, b_ready, c_ready, d_ready;

  logic [1:0]       ptr;
  logic             busy;

  modport master (
    output mode, sel, in_valid, in_data,
    output a_ready, b_ready, c_ready, d_ready,
    input  in_ready,
    input  a_valid, b_valid, c_valid, d_valid,
    input  a_data, b_data, c_data, d_data,
    input  ptr, busy
  );

  modport slave (
    input  mode, sel, in_valid, in_data,
    input  a_ready, b_ready, c_ready, d_ready,
    output in_ready,
    output a_valid, b_valid, c_valid, d_valid,
    output a_data, b_data, c_data, d_data,
    output ptr, busy
  );

endinterface

// File: rtl/demux4_chan_slot.sv
// One-entry channel register with full flag; data reads zero whenever the slot is empty.
module demux4_chan_slot #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             drain_ready,
  output logic             full,
  output logic [WIDTH-1:0] data
);

  // load is only ever raised while empty, so it never collides with a drain
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      data <= '0;
    end else if (load) begin
      full <= 1'b1;
      data <= load_data;
    end else if (full && drain_ready) begin
      full <= 1'b0;
      data <= '0;
    end
  end

endmodule

// File: rtl/demux4_rr_sched.sv
// 1-to-4 demux sequencer: strict round-robin or direct dispatch into four one-entry slots.
module demux4_rr_sched
  import demux4_rr_sched_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input logic               clk,
  input logic               rst,
  demux4_rr_sched_if.slave  bus
);

  logic [1:0]       ptr_q;
  logic [1:0]       tgt;
  logic             accept;
  logic [3:0]       full;
  logic [3:0]       ready;
  logic [3:0]       load;
  logic [WIDTH-1:0] data [NUM_CH];

  assign tgt          = (bus.mode == MODE_DIRECT) ? bus.sel : ptr_q;
  assign bus.in_ready = ~rst & ~full[tgt];
  assign accept       = bus.in_valid & bus.in_ready;

  always_comb begin
    load = '0;
    if (accept) load[tgt] = 1'b1;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
    demux4_chan_slot #(.WIDTH(WIDTH)) u_slot (
      .clk         (clk),
      .rst         (rst),
      .load        (load[i]),
      .load_data   (bus.in_data),
      .drain_ready (ready[i]),
      .full        (full[i]),
      .data        (data[i])
    );
  end

  // pointer moves only on an accepted round-robin word; direct mode holds it
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 2'd0;
    end else if (accept && bus.mode == MODE_RR) begin
      ptr_q <= ptr_q + 2'd1;
    end
  end

  assign ready[CH_A] = bus.a_ready;
  assign ready[CH_B] = bus.b_ready;
  assign ready[CH_C] = bus.c_ready;
  assign ready[CH_D] = bus.d_ready;

  assign bus.a_valid = full[CH_A];
  assign bus.b_valid = full[CH_B];
  assign bus.c_valid = full[CH_C];
  assign bus.d_valid = full[CH_D];

  assign bus.a_data = data[CH_A];
  assign bus.b_data = data[CH_B];
  assign bus.c_data = data[CH_C];
  assign bus.d_data = data[CH_D];

  assign bus.ptr  = ptr_q;
  assign bus.busy = |full;

endmodule
